phase_sequencer: RTL and testbench
==================================

# phase_sequencer

Parametrised multicycle execution sequencer for the processor top level. It steps the datapath through phases 1..NUM_PHASES per instruction and returns to an idle phase 0 when stopped. On top of the fixed 5-phase run/stop sequencer it adds:
- run and single-step modes
- a stall input that freezes the current phase
- a halt request from control
- a retired-instruction counter
- an optional PC breakpoint

Its `phase` output drives `control`; its `pc_e` output drives `program_counter`.

## Interface
- `NUM_PHASES`, default 5: phases per instruction; legal range 2..(2**PHASE_W − 1).
- `PHASE_W`, default 3: width of `phase`.
- `CNT_W`, default 16: width of the instruction counter.
- `ADDR_W`, default 16: width of the PC and breakpoint address.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `exec`  in  1  run/stop pushbutton, active-low, already debounced; asynchronous to `clk`.
- `step_mode`  in  1  1 = each start executes exactly one instruction.
- `stall`  in  1  1 = hold the current phase (ignored in phase 0).
- `halt_req`  in  1  halt after the current instruction; sampled only in phase NUM_PHASES.
- `pc`  in  ADDR_W  current PC value (breakpoint compare only).
- `bp_addr`  in  ADDR_W  breakpoint address (breakpoint build only).
- `bp_en`  in  1  breakpoint enable (breakpoint build only).
- `phase`  out  PHASE_W  0 = idle; 1..NUM_PHASES = active phase.
- `executing`  out  1  1 while not idle.
- `pc_e`  out  1  one-cycle PC advance strobe.
- `instr_count`  out  CNT_W  retired instructions.
- `bp_hit`  out  1  last stop was caused by the breakpoint (breakpoint build only).

## Operation
Button handling:
- `exec` passes through two synchronizer flops, then a third flop used for edge detection.
- A press is a 1→0 transition between the second and third flops; it lasts one cycle.

States:
- IDLE: `phase`=0.
- RUN: `phase`=1..NUM_PHASES.
- A `stop_pend` flag is held internally.

Transitions:
- IDLE and press → `phase`=1, `executing`=1, `stop_pend`=0, `bp_hit`=0.
- IDLE with no press → stay in IDLE.
- RUN, `stall`=1 → `phase` holds and no other state changes, except that a press still sets `stop_pend`.
- RUN, `phase`<NUM_PHASES, `stall`=0 → `phase`+1.
- RUN, `phase`=NUM_PHASES, `stall`=0 → the instruction retires and `instr_count` increments (wraps modulo 2**CNT_W). Then:
  - if `stop_pend`, a press in this cycle, `halt_req`, or `step_mode` → IDLE, `executing`=0;
  - otherwise → `phase`=1.
- A press during RUN sets `stop_pend`. The current instruction always completes; no instruction is aborted mid-phase.
- Simultaneous stop causes (press, `halt_req`, `step_mode`, breakpoint) produce a single return to IDLE.

PC strobe:
- `pc_e`=1 for exactly one cycle: the first cycle `phase`=NUM_PHASES.
- It is not repeated while stalled in the last phase.

Other rules:
- `instr_count` is cleared only by reset; stopping and restarting preserve it.
- Reset asserted mid-instruction: all state clears immediately and asynchronously.
- Reset values: `phase`=0, `executing`=0, `pc_e`=0, `instr_count`=0, `bp_hit`=0, `stop_pend`=0, synchronizer flops=1.

## Timing
- Start latency: if `exec` falls before rising edge E0, `phase`=1 after edge E2.
- Instruction length: NUM_PHASES cycles with no stall, plus one cycle per stalled cycle.
- Back-to-back instructions: phase NUM_PHASES is followed directly by phase 1; there is no idle bubble.
- A press detected on the same edge as the final phase's exit is honoured for that instruction.
- `pc_e` is registered. It rises on the edge that enters phase NUM_PHASES and falls one edge later.

## Configuration
Macro: `PHASE_SEQ_BREAKPOINT_EN`.

When defined:
- `bp_addr`, `bp_en` and `bp_hit` exist.
- In phase 1, with `bp_en`=1 and `pc`==`bp_addr`: `stop_pend` is set and `bp_hit` is set.
- That instruction completes, then the sequencer returns to IDLE.
- The compare is suppressed during the first instruction after each start, so resuming from a breakpoint advances past it.

When undefined:
- The breakpoint ports are absent and there is no compare logic.
- All other behaviour is identical.

## Test plan
All scenarios use NUM_PHASES=5.
- Reset, then press `exec` with `step_mode`=0 → `phase` sequence 1,2,3,4,5,1,2… starting on E2; `pc_e` high only during each phase-5 cycle.
- `step_mode`=1, press → phases 1..5 once, then `phase`=0, `executing`=0, `instr_count`=1.
- Running, press during phase 2 → the instruction finishes through phase 5, then IDLE; `instr_count` has incremented for that instruction.
- `stall`=1 for 3 cycles in phase 3 → `phase` stays 3 for 4 cycles; the instruction takes 8 cycles. `stall`=1 for 2 cycles in phase 5 → `pc_e` high for only one cycle.
- `halt_req`=1 in phase 5 together with a press → exactly one return to IDLE. Then drop `rst` during phase 4 → all outputs 0 immediately.
- Breakpoint build, `bp_addr`=0x0003, `bp_en`=1, `pc` counting 0,1,2,3… → stop after the instruction at 0x0003 with `bp_hit`=1. Press again → execution continues past 0x0003 and `bp_hit`=0.

Source files
------------

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - multicycle phase sequencer with run/step/stall/halt and retired-instruction count
// Optional PC breakpoint enabled by defining PHASE_SEQ_BREAKPOINT_EN.
module phase_sequencer #(
  parameter int NUM_PHASES = 5,
  parameter int PHASE_W    = 3,
  parameter int CNT_W      = 16,
  parameter int ADDR_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exec,
  input  logic               step_mode,
  input  logic               stall,
  input  logic               halt_req,
  input  logic [ADDR_W-1:0]  pc,
`ifdef PHASE_SEQ_BREAKPOINT_EN
  input  logic [ADDR_W-1:0]  bp_addr,
  input  logic               bp_en,
  output logic               bp_hit,
`endif
  output logic [PHASE_W-1:0] phase,
  output logic               executing,
  output logic               pc_e,
  output logic [CNT_W-1:0]   instr_count
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [PHASE_W-1:0] ONE  = PHASE_W'(1);
  localparam logic [PHASE_W-1:0] LAST = PHASE_W'(NUM_PHASES);

  state_t     state;
  logic [2:0] sync;
  logic       press;
  logic       stop_pend;
  logic       stop_now;

  // sync[1:0] synchronise the button, sync[2] delays it for falling-edge detection
  assign press    = sync[2] & ~sync[1];
  assign stop_now = stop_pend | press | halt_req | step_mode;

`ifdef PHASE_SEQ_BREAKPOINT_EN
  logic first_instr;
  logic bp_match;
  // first instruction after a start never matches, so a resume steps past the breakpoint
  assign bp_match = bp_en && (pc == bp_addr) && !first_instr && (phase == ONE);
`else
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      phase       <= '0;
      executing   <= 1'b0;
      pc_e        <= 1'b0;
      instr_count <= '0;
      stop_pend   <= 1'b0;
      sync        <= 3'b111;
`ifdef PHASE_SEQ_BREAKPOINT_EN
      bp_hit      <= 1'b0;
      first_instr <= 1'b0;
`endif
    end else begin
      sync <= {sync[1:0], exec};
      pc_e <= 1'b0;
      case (state)
        IDLE: begin
          if (press) begin
            state     <= RUN;
            phase     <= ONE;
            executing <= 1'b1;
            stop_pend <= 1'b0;
`ifdef PHASE_SEQ_BREAKPOINT_EN
            bp_hit      <= 1'b0;
            first_instr <= 1'b1;
`endif
          end
        end
        RUN: begin
          if (press) stop_pend <= 1'b1;
          if (!stall) begin
            if (phase != LAST) begin
              phase <= phase + ONE;
              pc_e  <= (phase == LAST - ONE);
`ifdef PHASE_SEQ_BREAKPOINT_EN
              if (bp_match) begin
                stop_pend <= 1'b1;
                bp_hit    <= 1'b1;
              end
`endif
            end else begin
              instr_count <= instr_count + CNT_W'(1);
`ifdef PHASE_SEQ_BREAKPOINT_EN
              first_instr <= 1'b0;
`endif
              if (stop_now) begin
                state     <= IDLE;
                phase     <= '0;
                executing <= 1'b0;
              end else begin
                phase <= ONE;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - table, directed and randomized checks of phase_sequencer against a reference model
module tb_phase_sequencer;
  localparam int NP = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        exec = 1'b1;
  logic        step_mode = 1'b0;
  logic        stall = 1'b0;
  logic        halt_req = 1'b0;
  logic [15:0] pc = '0;
  logic [2:0]  phase;
  logic        executing;
  logic        pc_e;
  logic [15:0] instr_count;
`ifdef PHASE_SEQ_BREAKPOINT_EN
  logic [15:0] bp_addr = '0;
  logic        bp_en = 1'b0;
  logic        bp_hit;
`endif

  int total = 0;
  int bad = 0;

  int m_phase, m_count;
  bit m_pend, m_first, m_bphit, m_pce;
  bit hist[$];

  typedef struct {
    bit ex;
    int ph;
    bit pce;
    int cnt;
  } vec_t;
  vec_t tbl[14];

  always #5 clk = ~clk;

  phase_sequencer #(.NUM_PHASES(NP), .PHASE_W(3), .CNT_W(16), .ADDR_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .exec(exec),
    .step_mode(step_mode),
    .stall(stall),
    .halt_req(halt_req),
    .pc(pc),
`ifdef PHASE_SEQ_BREAKPOINT_EN
    .bp_addr(bp_addr),
    .bp_en(bp_en),
    .bp_hit(bp_hit),
`endif
    .phase(phase),
    .executing(executing),
    .pc_e(pc_e),
    .instr_count(instr_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_count = 0; m_pend = 0; m_first = 0; m_bphit = 0; m_pce = 0;
    hist = {1'b1, 1'b1, 1'b1};
  endtask

  // Model of one rising edge: hist holds the exec levels seen at the three previous edges
  task automatic model_edge();
    bit press;
    int prev;
    press = hist[0] && !hist[1];
    void'(hist.pop_front());
    hist.push_back(exec);
    prev = m_phase;
    if (m_phase == 0) begin
      if (press) begin
        m_phase = 1; m_pend = 0; m_bphit = 0; m_first = 1;
      end
    end else if (stall) begin
      if (press) m_pend = 1;
    end else if (m_phase < NP) begin
      if (press) m_pend = 1;
`ifdef PHASE_SEQ_BREAKPOINT_EN
      if (m_phase == 1 && !m_first && bp_en && pc == bp_addr) begin
        m_pend = 1; m_bphit = 1;
      end
`endif
      m_phase++;
    end else begin
      m_count = (m_count + 1) % 65536;
      m_first = 0;
      m_phase = (m_pend || press || halt_req || step_mode) ? 0 : 1;
    end
    m_pce = (m_phase == NP) && (prev != NP);
  endtask

  task automatic compare_all();
    chk("phase", int'(phase), m_phase);
    chk("executing", int'(executing), int'(m_phase != 0));
    chk("pc_e", int'(pc_e), int'(m_pce));
    chk("instr_count", int'(instr_count), m_count);
`ifdef PHASE_SEQ_BREAKPOINT_EN
    chk("bp_hit", int'(bp_hit), int'(m_bphit));
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    pc = 16'(m_count);
  endtask

  task automatic do_reset();
    exec = 1; stall = 0; halt_req = 0; step_mode = 0; pc = '0;
    rst = 0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst = 1;
  endtask

  task automatic press_btn();
    exec = 0;
    cyc();
    cyc();
    exec = 1;
  endtask

  task automatic wait_phase(input int p, input int budget);
    int n = 0;
    while (int'(phase) != p && n < budget) begin
      cyc();
      n++;
    end
    if (int'(phase) != p) chk("wait_phase_timeout", int'(phase), p);
  endtask

  initial begin
    int len, n3, n5, npce, c0;

    tbl[0]  = '{1'b0, 0, 1'b0, 0};
    tbl[1]  = '{1'b0, 0, 1'b0, 0};
    tbl[2]  = '{1'b1, 1, 1'b0, 0};
    tbl[3]  = '{1'b1, 2, 1'b0, 0};
    tbl[4]  = '{1'b1, 3, 1'b0, 0};
    tbl[5]  = '{1'b1, 4, 1'b0, 0};
    tbl[6]  = '{1'b1, 5, 1'b1, 0};
    tbl[7]  = '{1'b1, 1, 1'b0, 1};
    tbl[8]  = '{1'b1, 2, 1'b0, 1};
    tbl[9]  = '{1'b0, 3, 1'b0, 1};
    tbl[10] = '{1'b0, 4, 1'b0, 1};
    tbl[11] = '{1'b1, 5, 1'b1, 1};
    tbl[12] = '{1'b1, 0, 1'b0, 2};
    tbl[13] = '{1'b1, 0, 1'b0, 2};

    do_reset();
    for (int j = 0; j < 14; j++) begin
      exec = tbl[j].ex;
      cyc();
      chk($sformatf("tbl%0d_phase", j), int'(phase), tbl[j].ph);
      chk($sformatf("tbl%0d_pc_e", j), int'(pc_e), int'(tbl[j].pce));
      chk($sformatf("tbl%0d_count", j), int'(instr_count), tbl[j].cnt);
    end

    // single step: exactly one instruction
    do_reset();
    step_mode = 1;
    press_btn();
    wait_phase(1, 10);
    len = 0;
    while (phase != 0 && len < 20) begin
      len++;
      cyc();
    end
    chk("step_len", len, NP);
    chk("step_count", int'(instr_count), 1);
    chk("step_executing", int'(executing), 0);

    // press during phase 2 finishes the instruction, then stops
    step_mode = 0;
    press_btn();
    wait_phase(2, 10);
    c0 = int'(instr_count);
    press_btn();
    wait_phase(0, 20);
    chk("stop_count", int'(instr_count), c0 + 1);

    // three stalled cycles in phase 3
    step_mode = 1;
    press_btn();
    wait_phase(1, 10);
    len = 0; n3 = 0;
    while (phase != 0 && len < 30) begin
      if (phase == 3) begin
        n3++;
        if (n3 == 1) stall = 1;
        if (n3 == 4) stall = 0;
      end
      len++;
      cyc();
    end
    stall = 0;
    chk("stall3_cycles", n3, 4);
    chk("stall3_len", len, 8);

    // two stalled cycles in the last phase, single pc_e pulse
    press_btn();
    wait_phase(1, 10);
    len = 0; n5 = 0; npce = 0;
    while (phase != 0 && len < 30) begin
      if (phase == NP) begin
        n5++;
        npce += int'(pc_e);
        if (n5 == 1) stall = 1;
        if (n5 == 3) stall = 0;
      end
      len++;
      cyc();
    end
    stall = 0;
    chk("stall5_cycles", n5, 3);
    chk("stall5_pce_pulses", npce, 1);

    // halt_req and press both hit the final-phase exit: one return to idle
    step_mode = 0;
    press_btn();
    wait_phase(3, 20);
    c0 = int'(instr_count);
    exec = 0;
    cyc();
    exec = 1;
    cyc();
    chk("halt_at_last", int'(phase), NP);
    halt_req = 1;
    cyc();
    halt_req = 0;
    chk("halt_idle", int'(phase), 0);
    chk("halt_count", int'(instr_count), c0 + 1);
    for (int k = 0; k < 4; k++) cyc();
    chk("halt_stays_idle", int'(executing), 0);

    // asynchronous reset in phase 4
    press_btn();
    wait_phase(4, 20);
    do_reset();
    chk("rst_count", int'(instr_count), 0);

`ifdef PHASE_SEQ_BREAKPOINT_EN
    do_reset();
    bp_en = 1;
    bp_addr = 16'h0003;
    press_btn();
    wait_phase(1, 10);
    wait_phase(0, 60);
    chk("bp_hit_set", int'(bp_hit), 1);
    chk("bp_count", int'(instr_count), 4);
    press_btn();
    wait_phase(1, 10);
    chk("bp_hit_clear", int'(bp_hit), 0);
    len = 0;
    while (instr_count < 6 && len < 40) begin
      len++;
      cyc();
    end
    chk("bp_resumed", int'(executing), 1);
    bp_en = 0;
`endif

    // randomized run against the model
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      exec      = ($urandom_range(0, 9) != 0);
      stall     = ($urandom_range(0, 3) == 0);
      halt_req  = ($urandom_range(0, 15) == 0);
      if (k % 100 == 0) step_mode = ($urandom_range(0, 3) == 0);
`ifdef PHASE_SEQ_BREAKPOINT_EN
      if (k % 50 == 0) begin
        bp_en   = $urandom_range(0, 1);
        bp_addr = 16'($urandom_range(0, 40));
      end
`endif
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
